// File: rtl/xy_step_scheduler_pkg.sv
// Shared types and constants for the X/Y step scheduler: FSM states, timer modes
// and the minimum step period.
package xy_step_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWait,
        StPulse,
        StDone
    } sched_state_e;

    typedef enum logic [1:0] {
        TmrIdle,
        TmrWait,
        TmrPulse
    } tmr_mode_e;

    // Shortest legal major-axis period: one pulse high time plus an equal low time.
    function automatic int unsigned min_period(input int unsigned pulse_w);
        return 2 * pulse_w;
    endfunction

endpackage

// File: rtl/xy_step_scheduler_pulse_timer.sv
// Loadable down-counter timing the WAIT gap (period - pulse width) and the PULSE
// high time; each done flag is high in the last cycle of its interval.
module xy_step_scheduler_pulse_timer
    import xy_step_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PULSE_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_wait_i,
    input  logic             load_pulse_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             wait_done_o,
    output logic             pulse_done_o
);

    tmr_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired;

    assign expired = (cnt_q == '0);

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (load_pulse_i) begin
            mode_d = TmrPulse;
            cnt_d  = CNT_W'(PULSE_W - 1);
        end else if (load_wait_i) begin
            mode_d = TmrWait;
            cnt_d  = period_i - CNT_W'(PULSE_W + 1);
        end else if (mode_q != TmrIdle) begin
            if (expired) begin
                mode_d = TmrIdle;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= TmrIdle;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wait_done_o  = (mode_q == TmrWait) && expired;
    assign pulse_done_o = (mode_q == TmrPulse) && expired;

endmodule

// File: rtl/xy_step_scheduler.sv
// Two-axis Bresenham line sequencer: takes one (dx, dy, period) move and emits
// coordinated step/dir pulses while tracking the absolute X/Y position.
module xy_step_scheduler
    import xy_step_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PULSE_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_dx,
    input  logic [CNT_W-1:0] cmd_dy,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             abort,
    input  logic             zero_pos,
    output logic             step_x,
    output logic             step_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pos_x,
    output logic [CNT_W-1:0] pos_y
);

    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(min_period(PULSE_W));

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   dx_q, dx_d, dy_q, dy_d, period_q, period_d;
    logic [CNT_W-1:0]   major_q, major_d, minor_q, minor_d, left_q, left_d;
    logic [CNT_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [CNT_W:0] err_q, err_d, err_sub;
    logic               x_major_q, x_major_d, dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic               step_x_q, step_x_d, step_y_q, step_y_d;
    logic               abort_q, abort_d, aborted_q, aborted_d;
    logic               load_wait, load_pulse, wait_done, pulse_done;
    logic [CNT_W-1:0]   ax, ay, major, minor;
    logic               x_major;

    // Magnitudes are unsigned, so -2^(CNT_W-1) maps to 2^(CNT_W-1) steps.
    assign ax      = dx_q[CNT_W-1] ? (~dx_q + CNT_W'(1)) : dx_q;
    assign ay      = dy_q[CNT_W-1] ? (~dy_q + CNT_W'(1)) : dy_q;
    assign x_major = (ax >= ay);
    assign major   = x_major ? ax : ay;
    assign minor   = x_major ? ay : ax;
    assign err_sub = err_q - $signed({1'b0, minor_q});

    always_comb begin
        state_d    = state_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        period_d   = period_q;
        major_d    = major_q;
        minor_d    = minor_q;
        left_d     = left_q;
        err_d      = err_q;
        x_major_d  = x_major_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        step_x_d   = step_x_q;
        step_y_d   = step_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        abort_d    = abort_q;
        aborted_d  = aborted_q;
        load_wait  = 1'b0;
        load_pulse = 1'b0;

        case (state_q)
            StIdle: begin
                if (zero_pos) begin
                    pos_x_d = '0;
                    pos_y_d = '0;
                end
                if (cmd_valid) begin
                    dx_d     = cmd_dx;
                    dy_d     = cmd_dy;
                    period_d = (cmd_period < MinPeriod) ? MinPeriod : cmd_period;
                    dir_x_d  = ~cmd_dx[CNT_W-1];
                    dir_y_d  = ~cmd_dy[CNT_W-1];
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                abort_d   = 1'b0;
                aborted_d = 1'b0;
                x_major_d = x_major;
                major_d   = major;
                minor_d   = minor;
                left_d    = major;
                err_d     = {2'b00, major[CNT_W-1:1]};
                if (major == '0) begin
                    state_d = StDone;
                end else begin
                    load_wait = 1'b1;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (wait_done) begin
                    load_pulse = 1'b1;
                    state_d    = StPulse;
                    err_d      = err_sub[CNT_W] ? err_sub + $signed({1'b0, major_q}) : err_sub;
                    step_x_d   = x_major_q | err_sub[CNT_W];
                    step_y_d   = ~x_major_q | err_sub[CNT_W];
                    left_d     = left_q - CNT_W'(1);
                    // Adding all-ones is -1, adding 1 is +1.
                    if (step_x_d) pos_x_d = pos_x_q + {{(CNT_W-1){~dir_x_q}}, 1'b1};
                    if (step_y_d) pos_y_d = pos_y_q + {{(CNT_W-1){~dir_y_q}}, 1'b1};
                end
            end
            StPulse: begin
                abort_d = abort_q | abort;
                if (pulse_done) begin
                    step_x_d = 1'b0;
                    step_y_d = 1'b0;
                    if (left_q == '0) begin
                        aborted_d = 1'b0;
                        state_d   = StDone;
                    end else if (abort_q || abort) begin
                        aborted_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        load_wait = 1'b1;
                        state_d   = StWait;
                    end
                end
            end
            StDone: begin
                if (zero_pos) begin
                    pos_x_d = '0;
                    pos_y_d = '0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            dx_q      <= '0;
            dy_q      <= '0;
            period_q  <= '0;
            major_q   <= '0;
            minor_q   <= '0;
            left_q    <= '0;
            err_q     <= '0;
            x_major_q <= 1'b0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            step_x_q  <= 1'b0;
            step_y_q  <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            period_q  <= period_d;
            major_q   <= major_d;
            minor_q   <= minor_d;
            left_q    <= left_d;
            err_q     <= err_d;
            x_major_q <= x_major_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            step_x_q  <= step_x_d;
            step_y_q  <= step_y_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    xy_step_scheduler_pulse_timer #(
        .CNT_W  (CNT_W),
        .PULSE_W(PULSE_W)
    ) u_timer (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .load_wait_i (load_wait),
        .load_pulse_i(load_pulse),
        .period_i    (period_q),
        .wait_done_o (wait_done),
        .pulse_done_o(pulse_done)
    );

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StSetup) || (state_q == StWait) || (state_q == StPulse);
    assign done      = (state_q == StDone);
    assign aborted   = done && aborted_q;
    assign step_x    = step_x_q;
    assign step_y    = step_y_q;
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;

endmodule

// File: tb/tb_xy_step_scheduler.sv
// Bench for xy_step_scheduler: directed moves with literal expectations plus
// random moves, all cycles compared against a closed-form timeline model.
module tb_xy_step_scheduler;

    localparam int PW = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_dx = '0, cmd_dy = '0, cmd_period = '0;
    logic        abort = 1'b0, zero_pos = 1'b0;
    logic        step_x, step_y, dir_x, dir_y, busy, done, aborted;
    logic [31:0] pos_x, pos_y;

    xy_step_scheduler #(
        .CNT_W  (32),
        .PULSE_W(PW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dx    (cmd_dx),
        .cmd_dy    (cmd_dy),
        .cmd_period(cmd_period),
        .abort     (abort),
        .zero_pos  (zero_pos),
        .step_x    (step_x),
        .step_y    (step_y),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pos_x     (pos_x),
        .pos_y     (pos_y)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    // Timeline model: offsets t are relative to the accept cycle.
    // Pulse k rises at r1 + (k-1)*Pe, r1 = 2 + Pe - PW, and is high PW cycles.
    typedef struct packed {
        logic        step_x, step_y, dir_x, dir_y, busy, done, aborted, cmd_ready;
        logic [31:0] pos_x, pos_y;
    } obs_t;

    bit          m_active = 1'b0, m_xmaj, m_dirx = 1'b0, m_diry = 1'b0, m_ab;
    longint      m_c0, m_M, m_minor, m_pe, m_N, m_done_t, m_r1;
    logic [31:0] base_x = '0, base_y = '0;
    longint      cur_abort = -1;

    // Minor-axis steps taken after k major steps, from err staying in [0, M).
    function automatic longint n_minor(input longint k);
        if (m_M == 0 || k <= 0) return 0;
        return (k * m_minor - m_M / 2 + m_M - 1) / m_M;
    endfunction

    function automatic longint n_started(input longint t);
        longint k;
        if (m_M == 0 || t < m_r1) return 0;
        k = (t - m_r1) / m_pe + 1;
        return (k < m_N) ? k : m_N;
    endfunction

    function automatic obs_t expect_at(input longint c);
        obs_t   o;
        longint t, ks, nk, xs, ys;
        bit     mstep;
        o = '0;
        o.cmd_ready = 1'b1;
        o.dir_x = m_dirx;
        o.dir_y = m_diry;
        o.pos_x = base_x;
        o.pos_y = base_y;
        if (m_active) begin
            t  = c - m_c0;
            ks = n_started(t);
            nk = n_minor(ks);
            xs = m_xmaj ? ks : nk;
            ys = m_xmaj ? nk : ks;
            o.pos_x = base_x + 32'(m_dirx ? xs : -xs);
            o.pos_y = base_y + 32'(m_diry ? ys : -ys);
            if (t <= m_done_t) o.cmd_ready = 1'b0;
            if (t < m_done_t) o.busy = 1'b1;
            if (t == m_done_t) begin
                o.done = 1'b1;
                o.aborted = m_ab;
            end
            if (ks > 0 && (t - (m_r1 + (ks - 1) * m_pe)) < PW) begin
                mstep = (nk > n_minor(ks - 1));
                o.step_x = m_xmaj ? 1'b1 : mstep;
                o.step_y = m_xmaj ? mstep : 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_accept(input longint c0, input logic [31:0] dx, input logic [31:0] dy,
                                input logic [31:0] per, input longint a, input bit zero);
        obs_t   cur;
        longint ax, ay, k;
        cur = expect_at(c0);
        base_x = zero ? 32'd0 : cur.pos_x;
        base_y = zero ? 32'd0 : cur.pos_y;
        ax = longint'($signed(dx));
        ay = longint'($signed(dy));
        if (ax < 0) ax = -ax;
        if (ay < 0) ay = -ay;
        m_xmaj  = (ax >= ay);
        m_M     = m_xmaj ? ax : ay;
        m_minor = m_xmaj ? ay : ax;
        m_dirx  = !dx[31];
        m_diry  = !dy[31];
        m_pe    = (per < 32'(2 * PW)) ? longint'(2 * PW) : longint'(per);
        m_r1    = 2 + m_pe - PW;
        m_c0    = c0;
        m_ab    = 1'b0;
        m_active = 1'b1;
        if (m_M == 0) begin
            m_N = 0;
            m_done_t = 2;
        end else begin
            m_N = m_M;
            m_done_t = m_r1 + (m_M - 1) * m_pe + PW;
            if (a >= 2 && a < m_done_t) begin
                if (a >= m_r1 && ((a - m_r1) % m_pe) < PW) begin
                    k = (a - m_r1) / m_pe + 1;
                    m_N = k;
                    m_done_t = m_r1 + (k - 1) * m_pe + PW;
                    m_ab = (k < m_M);
                end else begin
                    m_N = (a < m_r1) ? 0 : (a - m_r1) / m_pe + 1;
                    m_done_t = a + 1;
                    m_ab = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        base_x = '0;
        base_y = '0;
        m_dirx = 1'b0;
        m_diry = 1'b0;
    endtask

    always @(negedge clock) begin : compare
        obs_t e;
        if (chk_en) begin
            e = expect_at(cyc);
            chk("step_x", 32'(step_x), 32'(e.step_x));
            chk("step_y", 32'(step_y), 32'(e.step_y));
            chk("dir_x", 32'(dir_x), 32'(e.dir_x));
            chk("dir_y", 32'(dir_y), 32'(e.dir_y));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("aborted", 32'(aborted), 32'(e.aborted));
            chk("cmd_ready", 32'(cmd_ready), 32'(e.cmd_ready));
            chk("pos_x", pos_x, e.pos_x);
            chk("pos_y", pos_y, e.pos_y);
        end
    end

    // Observed pulse edges and done, for the literal checks.
    longint rx[$], ry[$];
    longint done_cyc = -1;
    logic   done_ab = 1'b0, px = 1'b0, py = 1'b0;
    always @(negedge clock) begin
        if (step_x && !px) rx.push_back(cyc);
        if (step_y && !py) ry.push_back(cyc);
        px = step_x;
        py = step_y;
        if (done) begin
            done_cyc = cyc;
            done_ab = aborted;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        rx.delete();
        ry.delete();
        done_cyc = -1;
    endtask

    task automatic start_move(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] per,
                              input longint a, input bit zero, input bit hold);
        longint c0;
        cmd_dx = dx;
        cmd_dy = dy;
        cmd_period = per;
        cmd_valid = 1'b1;
        zero_pos = zero;
        c0 = cyc;
        tick();
        model_accept(c0, dx, dy, per, a, zero);
        cur_abort = a;
        zero_pos = 1'b0;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_dx = $urandom;
            cmd_dy = $urandom;
            cmd_period = $urandom;
        end
    endtask

    task automatic run_until(input longint tend);
        longint t;
        t = cyc - m_c0;
        while (t < tend) begin
            abort = (t == cur_abort);
            if (t == m_done_t) cmd_valid = 1'b0;
            tick();
            t = cyc - m_c0;
        end
        abort = 1'b0;
    endtask

    task automatic run_to_idle();
        run_until(m_done_t + 1);
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycle(input bit z);
        zero_pos = z;
        tick();
        zero_pos = 1'b0;
        if (z) begin
            m_active = 1'b0;
            base_x = '0;
            base_y = '0;
        end
    endtask

    // Called just after a rising edge; asserts reset mid-cycle.
    task automatic apply_reset_mid();
        #2;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_step_x", 32'(step_x), 32'd0);
        chk("async_pos_x", pos_x, 32'd0);
        model_reset();
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pos_x", pos_x, 32'd0);
        chk("rst_pos_y", pos_y, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] dx, dy, per;
        longint      a;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_step_x", 32'(step_x), 32'd0);
        chk("reset_dir_x", 32'(dir_x), 32'd0);
        chk("reset_pos_x", pos_x, 32'd0);

        // Pure X move, 20-cycle spacing.
        clear_obs();
        start_move(32'd4, 32'd0, 32'd20, -1, 1'b1, 1'b0);
        run_to_idle();
        chk("x4_pulses", 32'(rx.size()), 32'd4);
        chk("x4_y_pulses", 32'(ry.size()), 32'd0);
        if (rx.size() == 4) begin
            chk("x4_first_rise", 32'(rx[0] - m_c0), 32'd18);
            chk("x4_spacing", 32'(rx[1] - rx[0]), 32'd20);
            chk("x4_done_after", 32'(done_cyc - rx[3]), 32'd4);
        end
        chk("x4_pos_x", pos_x, 32'd4);
        chk("x4_dir_x", 32'(dir_x), 32'd1);

        // Diagonal-ish move, negative X.
        clear_obs();
        start_move(-32'sd6, 32'd3, 32'd10, -1, 1'b1, 1'b0);
        run_to_idle();
        chk("d63_y_pulses", 32'(ry.size()), 32'd3);
        if (rx.size() == 6 && ry.size() == 3) begin
            chk("d63_y1_on_x2", 32'(ry[0] - rx[1]), 32'd0);
            chk("d63_y3_on_x6", 32'(ry[2] - rx[5]), 32'd0);
        end
        chk("d63_pos_x", pos_x, 32'hFFFF_FFFA);
        chk("d63_pos_y", pos_y, 32'd3);
        chk("d63_dir_x", 32'(dir_x), 32'd0);
        chk("d63_dir_y", 32'(dir_y), 32'd1);

        // Null move.
        clear_obs();
        start_move(32'd0, 32'd0, 32'd10, -1, 1'b0, 1'b0);
        run_to_idle();
        chk("zero_done_lat", 32'(done_cyc - m_c0), 32'd2);
        chk("zero_aborted", 32'(done_ab), 32'd0);
        chk("zero_pulses", 32'(rx.size()), 32'd0);

        // Abort on the 2nd cycle of pulse 3: r3 = 14 + 32.
        clear_obs();
        start_move(32'd10, 32'd0, 32'd16, 47, 1'b1, 1'b0);
        run_to_idle();
        chk("abort_pulses", 32'(rx.size()), 32'd3);
        if (rx.size() == 3) chk("abort_full_pulse", 32'(done_cyc - rx[2]), 32'd4);
        chk("abort_flag", 32'(done_ab), 32'd1);
        chk("abort_pos_x", pos_x, 32'd3);

        // Clamped period with cmd_valid held through the move.
        clear_obs();
        start_move(32'd3, 32'd0, 32'd3, -1, 1'b1, 1'b1);
        run_to_idle();
        repeat (5) idle_cycle(1'b0);
        chk("clamp_pulses", 32'(rx.size()), 32'd3);
        if (rx.size() >= 2) chk("clamp_spacing", 32'(rx[1] - rx[0]), 32'd8);

        // Async reset in the middle of the first pulse.
        clear_obs();
        start_move(32'd10, 32'd0, 32'd16, -1, 1'b1, 1'b0);
        run_until(15);
        chk("mid_pulse_high", 32'(step_x), 32'd1);
        apply_reset_mid();

        // Most-negative dx: check the first three pulses, then reset out.
        clear_obs();
        start_move(32'h8000_0000, 32'd0, 32'd10, -1, 1'b1, 1'b0);
        run_until(33);
        chk("min_pulses", 32'(rx.size()), 32'd3);
        if (rx.size() == 3) chk("min_spacing", 32'(rx[2] - rx[1]), 32'd10);
        chk("min_dir_x", 32'(dir_x), 32'd0);
        chk("min_pos_x", pos_x, 32'hFFFF_FFFD);
        apply_reset_mid();

        for (int i = 0; i < 40; i++) begin
            dx  = 32'($urandom_range(0, 24)) - 32'd12;
            dy  = ($urandom_range(0, 5) == 0) ? dx : 32'($urandom_range(0, 24)) - 32'd12;
            per = 32'($urandom_range(0, 24));
            a   = ($urandom_range(0, 9) < 3) ? longint'($urandom_range(1, 200)) : -1;
            if ($urandom_range(0, 6) == 0) idle_cycle(1'b1);
            repeat ($urandom_range(0, 2)) idle_cycle(1'b0);
            start_move(dx, dy, per, a, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
            run_to_idle();
        end
        repeat (3) idle_cycle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
